fpaddsub_align_stage: RTL and testbench
=======================================

Name: fpaddsub_align_stage

Overview:
- Alignment stage that directly consumes the pre-alignment outputs of the pipelined FP add/sub datapath.
- Right-shifts the smaller mantissa field (MminS, 32 bits) by Shift over two registered sub-stages: coarse ×8, then fine 0–7.
- Produces an OR-reduced sticky bit from all bits shifted out.
- Carries the side-band fields (signs, common exponent, MaxAB, Mmax, InputExc) alongside, under a valid/ready elastic handshake.

Parameters:
- STAGES_FIXED, 2, number of pipeline registers; fixed value, documents the latency only, no other value supported.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  pre-align bundle valid
- in_ready  out  1  stage can accept the bundle this cycle
- Sa  in  1  A sign
- Sb  in  1  B sign
- CExp  in  8  common exponent
- MaxAB  in  1  0 = A larger, 1 = B larger
- Shift  in  5  right-shift amount, 0..25 (values 26..31 treated as 25)
- MminS  in  32  smaller mantissa in bits 31:7; bits 6:0 are zero
- Mmax  in  25  larger mantissa
- InputExc  in  5  exception vector, passed through
- out_valid  out  1  output bundle valid
- out_ready  in  1  downstream accepts
- SaO, SbO, CExpO, MaxABO, MmaxO, InputExcO  out  1/1/8/1/25/5  registered pass-through of the inputs
- MminA  out  32  MminS >> Shift, zero-filled from the MSB
- Sticky  out  1  OR of every bit of MminS shifted below bit 0

Behaviour:
- Reset (async, rst=1): v1, v2, out_valid = 0. All data registers, MminA and Sticky = 0. Outputs stay at these values until the first accepted transfer after rst deasserts.
- Shift saturation: eff = (Shift > 25) ? 25 : Shift. Computed combinationally before stage 1.
- Stage 1 register, captured when in_valid & in_ready:
  - c = MminS >> (8 * eff[4:3])
  - s1 = OR of bits discarded by the coarse shift
  - eff[2:0], side-band fields
- Stage 2 register, captured when v1 & load2:
  - MminA = c >> eff[2:0]
  - Sticky = s1 | OR of bits discarded by the fine shift
  - side-band fields
- Handshake:
  - load2 = ~v2 | out_ready
  - load1 = ~v1 | load2
  - in_ready = load1 (combinational from out_ready; no registered skid)
  - v1 next = in_valid & in_ready, else (v1 & ~load2 ? 1 : 0) when not loading
  - v2 next = v1 when load2, else held
  - out_valid = v2
- Latency: 2 cycles from acceptance to out_valid with out_ready held high. Throughput 1 bundle/cycle.
- Stall: out_valid & ~out_ready freezes stage 2 data and out_valid. Stage 1 fills if empty, then freezes; in_ready drops only when both stages are full. Outputs must not change while out_valid & ~out_ready.
- Simultaneous accept and drain: when both stages are full and out_ready=1, the stage 2 bundle retires, stage 1 moves to stage 2, and a new input is accepted, all in the same cycle. No bubble.
- in_valid with in_ready=0: no capture; the upstream holds its bundle.
- Reset mid-operation: all in-flight bundles are discarded. in_ready = 1 the cycle after rst deasserts.
- Arithmetic:
  - Shifts are logical and zero-fill.
  - Shift=0 gives MminA = MminS, Sticky = 0.
  - Sticky can be 1 only when eff > 7, because MminS[6:0] = 0; it must nevertheless be computed from all discarded bits, not inferred from eff.
- No arithmetic on CExp or Mmax. No exception handling beyond pass-through.

Test Plan:
- Reset, then one bundle: Shift=0, MminS=0xABCDEF80, out_ready=1 → out_valid exactly 2 cycles after acceptance; MminA=0xABCDEF80, Sticky=0; side-band fields unchanged.
- Shift=9, MminS=0x80000180 → MminA=0x00400000, Sticky=1. Shift=8, MminS=0x80000100 → MminA=0x00800001, Sticky=0.
- Shift=25, MminS=0xFFFFFF80 → MminA=0x0000007F, Sticky=1. Shift=31, same MminS → identical result (saturation).
- Back-to-back stream of 8 bundles, Shift=0..7, out_ready=1 → one result per cycle, in order, no bubbles; in_ready constantly 1.
- Stall: out_ready=0 for 5 cycles during a stream → in_ready falls after the 2nd accepted bundle; outputs constant while stalled; after release, all bundles delivered in order with none lost or duplicated.
- Assert rst while both stages are full → out_valid=0 immediately (asynchronous). After deassert, a new bundle emerges 2 cycles after acceptance; no stale bundle ever appears.

Source files
------------

// File: rtl/fpaddsub_align_stage.sv
// -----------------------------------------------------------------------------
// fpaddsub_align_stage
//
// Purpose:
//   Alignment stage of the pipelined FP add/sub datapath. It takes the
//   pre-alignment bundle and right-shifts the smaller mantissa (MminS) by
//   Shift, which saturates at 25. The shift is done in two registered steps:
//   a coarse shift by multiples of 8, then a fine shift of 0..7. Every bit
//   shifted below bit 0 is OR-reduced into Sticky. The side-band fields
//   travel alongside the mantissa. A valid/ready elastic handshake with no
//   skid buffer gives a latency of 2 cycles and a throughput of 1 bundle per
//   cycle.
//
// Ports:
//   clk, rst               clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready    upstream handshake (in_ready is combinational
//                          from out_ready)
//   Sa, Sb, CExp, MaxAB    side-band fields: signs, common exponent, and
//                          which operand is larger
//   Shift                  right-shift amount; 26..31 behave as 25
//   MminS                  smaller mantissa in bits 31:7
//   Mmax, InputExc         larger mantissa and exception vector (carried)
//   out_valid / out_ready  downstream handshake
//   SaO..InputExcO         registered side-band fields
//   MminA                  MminS >> Shift, zero-filled
//   Sticky                 OR of every bit of MminS shifted out
// -----------------------------------------------------------------------------
module fpaddsub_align_stage #(
    parameter int STAGES_FIXED = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        Sa,
    input  logic        Sb,
    input  logic [7:0]  CExp,
    input  logic        MaxAB,
    input  logic [4:0]  Shift,
    input  logic [31:0] MminS,
    input  logic [24:0] Mmax,
    input  logic [4:0]  InputExc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        SaO,
    output logic        SbO,
    output logic [7:0]  CExpO,
    output logic        MaxABO,
    output logic [24:0] MmaxO,
    output logic [4:0]  InputExcO,
    output logic [31:0] MminA,
    output logic        Sticky
);

    // The pipeline depth is structural; any other value is rejected.
    if (STAGES_FIXED != 2) begin : g_bad_stages
        $error("fpaddsub_align_stage supports STAGES_FIXED == 2 only");
    end

    localparam logic [31:0] ONES = 32'hFFFF_FFFF;

    // Handshake
    logic        r_v1;
    logic        r_v2;
    logic        w_load1;
    logic        w_load2;

    // Stage 1 contents
    logic [31:0] r_s1_c;
    logic        r_s1_sticky;
    logic [2:0]  r_s1_fine;
    logic        r_s1_sa;
    logic        r_s1_sb;
    logic [7:0]  r_s1_cexp;
    logic        r_s1_maxab;
    logic [24:0] r_s1_mmax;
    logic [4:0]  r_s1_exc;

    // Stage 2 contents (these drive the outputs directly)
    logic [31:0] r_s2_mmina;
    logic        r_s2_sticky;
    logic        r_s2_sa;
    logic        r_s2_sb;
    logic [7:0]  r_s2_cexp;
    logic        r_s2_maxab;
    logic [24:0] r_s2_mmax;
    logic [4:0]  r_s2_exc;

    // Shift datapath
    logic [4:0]  w_eff;
    logic [4:0]  w_coarse_amt;
    logic [31:0] w_coarse;
    logic        w_coarse_lost;
    logic [31:0] w_fine;
    logic        w_fine_lost;

    assign w_load2  = ~r_v2 | out_ready;
    assign w_load1  = ~r_v1 | w_load2;
    assign in_ready = w_load1;

    always_comb begin
        w_eff         = (Shift > 5'd25) ? 5'd25 : Shift;
        w_coarse_amt  = {w_eff[4:3], 3'b000};
        w_coarse      = MminS >> w_coarse_amt;
        // Low bits that fall off the coarse shift are selected by a mask
        // rather than inferred from the amount: MminS[6:0] is zero by
        // contract, but the stage must not rely on that.
        w_coarse_lost = |(MminS & ~(ONES << w_coarse_amt));
        w_fine        = r_s1_c >> r_s1_fine;
        w_fine_lost   = |(r_s1_c & ~(ONES << r_s1_fine));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
        end else begin
            // A full stage 1 that cannot move on is held by leaving r_v1 alone.
            if (w_load1) r_v1 <= in_valid;
            if (w_load2) r_v2 <= r_v1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_c      <= '0;
            r_s1_sticky <= 1'b0;
            r_s1_fine   <= '0;
            r_s1_sa     <= 1'b0;
            r_s1_sb     <= 1'b0;
            r_s1_cexp   <= '0;
            r_s1_maxab  <= 1'b0;
            r_s1_mmax   <= '0;
            r_s1_exc    <= '0;
        end else if (in_valid && w_load1) begin
            r_s1_c      <= w_coarse;
            r_s1_sticky <= w_coarse_lost;
            r_s1_fine   <= w_eff[2:0];
            r_s1_sa     <= Sa;
            r_s1_sb     <= Sb;
            r_s1_cexp   <= CExp;
            r_s1_maxab  <= MaxAB;
            r_s1_mmax   <= Mmax;
            r_s1_exc    <= InputExc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_mmina  <= '0;
            r_s2_sticky <= 1'b0;
            r_s2_sa     <= 1'b0;
            r_s2_sb     <= 1'b0;
            r_s2_cexp   <= '0;
            r_s2_maxab  <= 1'b0;
            r_s2_mmax   <= '0;
            r_s2_exc    <= '0;
        end else if (r_v1 && w_load2) begin
            r_s2_mmina  <= w_fine;
            r_s2_sticky <= r_s1_sticky | w_fine_lost;
            r_s2_sa     <= r_s1_sa;
            r_s2_sb     <= r_s1_sb;
            r_s2_cexp   <= r_s1_cexp;
            r_s2_maxab  <= r_s1_maxab;
            r_s2_mmax   <= r_s1_mmax;
            r_s2_exc    <= r_s1_exc;
        end
    end

    assign out_valid = r_v2;
    assign SaO       = r_s2_sa;
    assign SbO       = r_s2_sb;
    assign CExpO     = r_s2_cexp;
    assign MaxABO    = r_s2_maxab;
    assign MmaxO     = r_s2_mmax;
    assign InputExcO = r_s2_exc;
    assign MminA     = r_s2_mmina;
    assign Sticky    = r_s2_sticky;

endmodule

// File: tb/tb_fpaddsub_align_stage.sv
module tb_fpaddsub_align_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic        Sa, Sb, MaxAB;
    logic [7:0]  CExp;
    logic [4:0]  Shift;
    logic [31:0] MminS;
    logic [24:0] Mmax;
    logic [4:0]  InputExc;
    logic        SaO, SbO, MaxABO, Sticky;
    logic [7:0]  CExpO;
    logic [24:0] MmaxO;
    logic [4:0]  InputExcO;
    logic [31:0] MminA;

    // Input bundle: {Sa, Sb, CExp, MaxAB, Shift, MminS, Mmax, InputExc}
    logic [77:0] bin;
    assign {Sa, Sb, CExp, MaxAB, Shift, MminS, Mmax, InputExc} = bin;

    // Observed output bundle: {SaO, SbO, CExpO, MaxABO, MmaxO, InputExcO, MminA, Sticky}
    logic [73:0] obs;
    assign obs = {SaO, SbO, CExpO, MaxABO, MmaxO, InputExcO, MminA, Sticky};

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [73:0] exp_q[$];
    int          acc_q[$];

    fpaddsub_align_stage #(.STAGES_FIXED(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .Sa(Sa), .Sb(Sb), .CExp(CExp), .MaxAB(MaxAB), .Shift(Shift),
        .MminS(MminS), .Mmax(Mmax), .InputExc(InputExc),
        .out_valid(out_valid), .out_ready(out_ready),
        .SaO(SaO), .SbO(SbO), .CExpO(CExpO), .MaxABO(MaxABO),
        .MmaxO(MmaxO), .InputExcO(InputExcO),
        .MminA(MminA), .Sticky(Sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Bundle with random side-band fields; MminS[6:0] is forced to zero.
    function automatic logic [77:0] mk_bundle(input logic [4:0] sh, input logic [31:0] mm);
        logic [31:0] r0;
        logic [31:0] r1;
        r0 = $urandom;
        r1 = $urandom;
        return {r0[0], r0[1], r0[9:2], r0[10], sh, mm[31:7], 7'b0, r1[24:0], r0[15:11]};
    endfunction

    // Reference: shift the mantissa into a 64-bit window; the upper half is the
    // aligned result and anything left in the lower half was shifted out.
    function automatic logic [73:0] model(input logic [77:0] b);
        logic [4:0]  sh;
        logic [31:0] mm;
        int          eff;
        logic [63:0] wide;
        sh   = b[66:62];
        mm   = b[61:30];
        eff  = (int'(sh) > 25) ? 25 : int'(sh);
        wide = {mm, 32'b0} >> eff;
        return {b[77:76], b[75:68], b[67], b[29:5], b[4:0], wide[63:32], |wide[31:0]};
    endfunction

    task automatic test_reset();
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
            end
            checks++;
            if (obs !== 74'b0) begin
                errors++; $display("FAIL reset_outputs: got %h expected 0", obs);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_idle_valid: got %b expected 0", out_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        logic [77:0] b;
        logic [73:0] e;
        b = mk_bundle(5'd0, 32'hABCDEF80);
        e = model(b);
        out_ready = 1'b1;
        bin = b;
        in_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL single_accept: in_ready %b expected 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL single_early: out_valid %b expected 0 one cycle after accept", out_valid);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL single_latency: out_valid %b expected 1 two cycles after accept", out_valid);
        end
        checks++;
        if (MminA !== 32'hABCDEF80 || Sticky !== 1'b0) begin
            errors++; $display("FAIL single_shift0: got %h/%b expected abcdef80/0", MminA, Sticky);
        end
        checks++;
        if (obs !== e) begin
            errors++; $display("FAIL single_bundle: got %h expected %h", obs, e);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_arith();
        logic [4:0]  t_sh[4]  = '{5'd9, 5'd8, 5'd25, 5'd31};
        logic [31:0] t_mm[4]  = '{32'h80000180, 32'h80000100, 32'hFFFFFF80, 32'hFFFFFF80};
        logic [31:0] t_a[4]   = '{32'h00400000, 32'h00800001, 32'h0000007F, 32'h0000007F};
        logic        t_s[4]   = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [77:0] b;
        logic [73:0] e;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b = mk_bundle(t_sh[i], t_mm[i]);
            e = model(b);
            bin = b;
            in_valid = 1'b1;
            @(negedge clk);
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(negedge clk);
            @(posedge clk); #1;
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1) begin
                errors++; $display("FAIL arith_valid[%0d]: got %b expected 1", i, out_valid);
            end
            checks++;
            if (MminA !== t_a[i] || Sticky !== t_s[i]) begin
                errors++; $display("FAIL arith_vec[%0d] shift %0d: got %h/%b expected %h/%b",
                                   i, t_sh[i], MminA, Sticky, t_a[i], t_s[i]);
            end
            checks++;
            if (obs !== e) begin
                errors++; $display("FAIL arith_bundle[%0d]: got %h expected %h", i, obs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        int          sent = 0;
        logic [31:0] rm;
        logic        exp_rdy, exp_ov;
        exp_q.delete(); acc_q.delete();
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (sent < 8) begin
                rm = $urandom;
                bin = mk_bundle(5'(sent), rm);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++; $display("FAIL b2b_in_ready c%0d: got %b expected 1", c, in_ready);
            end
            exp_ov = (c >= 2 && c <= 9);
            checks++;
            if (out_valid !== exp_ov) begin
                errors++; $display("FAIL b2b_no_bubble c%0d: out_valid %b expected %b", c, out_valid, exp_ov);
            end
            exp_rdy = (exp_q.size() < 2) || out_ready;
            checks++;
            if (in_ready !== exp_rdy) begin
                errors++; $display("FAIL b2b_ready_model c%0d: got %b expected %b", c, in_ready, exp_rdy);
            end
            if (out_valid && exp_q.size() > 0) begin
                checks++;
                if (obs !== exp_q[0]) begin
                    errors++; $display("FAIL b2b_order c%0d: got %h expected %h", c, obs, exp_q[0]);
                end
            end
            if (out_valid && out_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front()); void'(acc_q.pop_front());
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(bin)); acc_q.push_back(cyc); sent++;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL b2b_drain: %0d bundles left, expected 0", exp_q.size());
        end
    endtask

    task automatic test_stall();
        int          sent = 0;
        int          got = 0;
        logic        pend = 1'b0;
        logic        prev_stall = 1'b0;
        logic [73:0] prev_obs = '0;
        logic [31:0] rm;
        logic        exp_rdy, exp_ov;
        exp_q.delete(); acc_q.delete();
        for (int c = 0; c < 30; c++) begin
            if (!pend) begin
                if (sent < 10) begin
                    rm = $urandom;
                    bin = mk_bundle(5'($urandom_range(0, 31)), rm);
                    in_valid = 1'b1;
                    pend = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = !(c >= 2 && c <= 6);
            @(negedge clk);
            if (c == 4) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++; $display("FAIL stall_full: in_ready %b expected 0 with both stages full", in_ready);
                end
            end
            exp_rdy = (exp_q.size() < 2) || out_ready;
            checks++;
            if (in_ready !== exp_rdy) begin
                errors++; $display("FAIL stall_in_ready c%0d: got %b expected %b", c, in_ready, exp_rdy);
            end
            exp_ov = (exp_q.size() > 0) && (cyc - acc_q[0] >= 2);
            checks++;
            if (out_valid !== exp_ov) begin
                errors++; $display("FAIL stall_out_valid c%0d: got %b expected %b", c, out_valid, exp_ov);
            end
            if (out_valid && exp_q.size() > 0) begin
                checks++;
                if (obs !== exp_q[0]) begin
                    errors++; $display("FAIL stall_data c%0d: got %h expected %h", c, obs, exp_q[0]);
                end
            end
            if (prev_stall) begin
                checks++;
                if (obs !== prev_obs || out_valid !== 1'b1) begin
                    errors++; $display("FAIL stall_hold c%0d: got %h/%b expected %h/1", c, obs, out_valid, prev_obs);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_obs   = obs;
            if (out_valid && out_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front()); void'(acc_q.pop_front()); got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(bin)); acc_q.push_back(cyc); sent++; pend = 1'b0;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++;
        if (got != 10 || exp_q.size() != 0) begin
            errors++; $display("FAIL stall_delivery: got %0d bundles (%0d pending) expected 10 (0)", got, exp_q.size());
        end
    endtask

    task automatic test_random();
        int          sent = 0;
        int          got = 0;
        logic        pend = 1'b0;
        logic [31:0] rm;
        logic        exp_rdy, exp_ov;
        exp_q.delete(); acc_q.delete();
        for (int c = 0; c < 1000 && !(sent == 150 && exp_q.size() == 0); c++) begin
            if (!pend) begin
                if (sent < 150 && $urandom_range(0, 3) != 0) begin
                    rm = $urandom;
                    bin = mk_bundle(5'($urandom_range(0, 31)), rm);
                    in_valid = 1'b1;
                    pend = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            exp_rdy = (exp_q.size() < 2) || out_ready;
            checks++;
            if (in_ready !== exp_rdy) begin
                errors++; $display("FAIL rand_in_ready c%0d: got %b expected %b", c, in_ready, exp_rdy);
            end
            exp_ov = (exp_q.size() > 0) && (cyc - acc_q[0] >= 2);
            checks++;
            if (out_valid !== exp_ov) begin
                errors++; $display("FAIL rand_out_valid c%0d: got %b expected %b", c, out_valid, exp_ov);
            end
            if (out_valid && exp_q.size() > 0) begin
                checks++;
                if (obs !== exp_q[0]) begin
                    errors++; $display("FAIL rand_data c%0d: got %h expected %h", c, obs, exp_q[0]);
                end
            end
            if (out_valid && out_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front()); void'(acc_q.pop_front()); got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(bin)); acc_q.push_back(cyc); sent++; pend = 1'b0;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++;
        if (got != 150 || exp_q.size() != 0) begin
            errors++; $display("FAIL rand_delivery: got %0d bundles (%0d pending) expected 150 (0)", got, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [77:0] b;
        logic [73:0] e;
        logic [31:0] rm;
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rm = $urandom;
            bin = mk_bundle(5'($urandom_range(0, 31)), rm);
            in_valid = 1'b1;
            @(negedge clk);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL rstmid_full: out_valid/in_ready %b/%b expected 1/0", out_valid, in_ready);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL rstmid_async: out_valid %b expected 0 immediately", out_valid);
        end
        checks++;
        if (obs !== 74'b0) begin
            errors++; $display("FAIL rstmid_clear: got %h expected 0", obs);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL rstmid_after: in_ready/out_valid %b/%b expected 1/0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        rm = $urandom;
        b = mk_bundle(5'($urandom_range(0, 31)), rm);
        e = model(b);
        out_ready = 1'b1;
        bin = b;
        in_valid = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL rstmid_stale: out_valid %b expected 0 one cycle after accept", out_valid);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || obs !== e) begin
            errors++; $display("FAIL rstmid_new: got %b/%h expected 1/%h", out_valid, obs, e);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++; $display("FAIL rstmid_ghost[%0d]: out_valid %b expected 0", i, out_valid);
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        bin       = '0;
        test_reset();
        test_single();
        test_arith();
        test_back_to_back();
        test_stall();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
